// File: rtl/bitstream_reader_pkg.sv
// Shared constants, state encoding and helpers for the bitstream byte reader.
package bitstream_reader_pkg;

   localparam int unsigned BYTE_WIDTH = 8;
   localparam int unsigned IN_LANES   = 5;
   localparam int unsigned DEPTH      = 16;
   localparam int unsigned ADDR_WIDTH = 4;
   localparam int unsigned OCC_WIDTH  = ADDR_WIDTH + 1;
   localparam int unsigned FLAG_WIDTH = 3;
   localparam int unsigned FLAG_MAX   = 5;
   localparam int unsigned WORD_WIDTH = 2 * BYTE_WIDTH;

   localparam logic [BYTE_WIDTH-1:0] PAD_BYTE = 8'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   // A lane count is legal when it names 0..IN_LANES lanes.
   function automatic logic flag_legal(input logic [FLAG_WIDTH-1:0] f);
      return f <= FLAG_WIDTH'(FLAG_MAX);
   endfunction

endpackage

// File: rtl/bitstream_byte_fifo.sv
// Circular byte store: up to IN_LANES bytes written per cycle, two bytes
// visible at the read pointer, and a byte occupancy counter.
module bitstream_byte_fifo
   import bitstream_reader_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           i_clear,
   input  logic [FLAG_WIDTH-1:0]          i_wr_cnt,
   input  logic [IN_LANES*BYTE_WIDTH-1:0] i_wr_data,
   input  logic [1:0]                     i_rd_cnt,
   output logic [BYTE_WIDTH-1:0]          o_rd_byte0,
   output logic [BYTE_WIDTH-1:0]          o_rd_byte1,
   output logic [OCC_WIDTH-1:0]           o_occ,
   output logic [OCC_WIDTH-1:0]           o_occ_nxt
);

   logic [BYTE_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [OCC_WIDTH-1:0]  r_occ;

   logic [ADDR_WIDTH-1:0] w_wr_base;
   logic [ADDR_WIDTH-1:0] w_rd_ptr1;

   // A clear restarts the stream, so same-cycle data lands at address 0.
   assign w_wr_base = i_clear ? '0 : r_wr_ptr;
   assign w_rd_ptr1 = r_rd_ptr + ADDR_WIDTH'(1);

   assign o_rd_byte0 = r_mem[r_rd_ptr];
   assign o_rd_byte1 = r_mem[w_rd_ptr1];
   assign o_occ      = r_occ;

   // Next occupancy: a clear discards everything including any same-cycle read.
   always_comb begin
      o_occ_nxt = r_occ;
      if (i_clear) begin
         o_occ_nxt = OCC_WIDTH'(i_wr_cnt);
      end else begin
         o_occ_nxt = r_occ + OCC_WIDTH'(i_wr_cnt) - OCC_WIDTH'(i_rd_cnt);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         r_occ <= o_occ_nxt;
         if (i_clear) begin
            r_wr_ptr <= ADDR_WIDTH'(i_wr_cnt);
            r_rd_ptr <= '0;
         end else begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(i_wr_cnt);
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(i_rd_cnt);
         end
      end
   end

   // Byte storage; lanes 0..i_wr_cnt-1 go to consecutive addresses with wrap.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(IN_LANES); i++) begin
         if (FLAG_WIDTH'(i) < i_wr_cnt) begin
            r_mem[w_wr_base + ADDR_WIDTH'(i)] <= i_wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

endmodule

// File: rtl/bitstream_byte_reader.sv
// Receive side of the carry-propagation output stage: buffers 5-lane byte
// beats and serves 16-bit big-endian words, zero-padding after end-of-stream.
module bitstream_byte_reader
   import bitstream_reader_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_flag_first,
   input  logic [BYTE_WIDTH-1:0] in_bit_1,
   input  logic [BYTE_WIDTH-1:0] in_bit_2,
   input  logic [BYTE_WIDTH-1:0] in_bit_3,
   input  logic [BYTE_WIDTH-1:0] in_bit_4,
   input  logic [BYTE_WIDTH-1:0] in_bit_5,
   input  logic [FLAG_WIDTH-1:0] in_flag,
   input  logic                  in_flag_last,
   output logic                  in_ready,
   output logic [WORD_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_pad,
   output logic                  out_eos,
   output logic [ADDR_WIDTH:0]   occupancy,
   output logic                  err_sticky
);

   state_t r_state;
   logic   r_last_seen;
   logic   r_err;

   logic                           w_flag_ok;
   logic                           w_wr_req;
   logic                           w_wr_ok;
   logic                           w_wr_acc;
   logic                           w_drop;
   logic                           w_last_acc;
   logic                           w_fire;
   logic [FLAG_WIDTH-1:0]          w_wr_cnt;
   logic [1:0]                     w_rd_cnt;
   logic [IN_LANES*BYTE_WIDTH-1:0] w_wr_data;
   logic [BYTE_WIDTH-1:0]          w_byte0;
   logic [BYTE_WIDTH-1:0]          w_byte1;
   logic [OCC_WIDTH-1:0]           w_occ;
   logic [OCC_WIDTH-1:0]           w_occ_nxt;
   state_t                         w_eos_state;

   assign w_wr_data = {in_bit_5, in_bit_4, in_bit_3, in_bit_2, in_bit_1};

   assign in_ready   = (OCC_WIDTH'(DEPTH) - w_occ) >= OCC_WIDTH'(IN_LANES);
   assign occupancy  = w_occ;
   assign err_sticky = r_err;

   // Admission: a new stream always has room; otherwise need space and no prior end.
   assign w_flag_ok  = flag_legal(in_flag);
   assign w_wr_req   = w_flag_ok && (in_flag != '0);
   assign w_wr_ok    = in_flag_first || (!r_last_seen && in_ready);
   assign w_wr_acc   = w_wr_req && w_wr_ok;
   assign w_drop     = w_wr_req && !w_wr_ok;
   assign w_wr_cnt   = w_wr_acc ? in_flag : '0;
   assign w_last_acc = in_flag_last && w_flag_ok && !w_drop && (in_flag_first || !r_last_seen);

   // Reads consume up to two bytes; DONE words and reads racing a restart consume nothing.
   assign w_fire   = out_valid && out_ready;
   assign w_rd_cnt = (in_flag_first || !w_fire || (r_state == DONE)) ? 2'd0 :
                     (w_occ >= OCC_WIDTH'(2)) ? 2'd2 : w_occ[1:0];

   // Where an accepted end-of-stream beat leads: drain remaining bytes or finish.
   assign w_eos_state = (w_occ_nxt == '0) ? DONE : DRAIN;

   bitstream_byte_fifo u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (in_flag_first),
      .i_wr_cnt   (w_wr_cnt),
      .i_wr_data  (w_wr_data),
      .i_rd_cnt   (w_rd_cnt),
      .o_rd_byte0 (w_byte0),
      .o_rd_byte1 (w_byte1),
      .o_occ      (w_occ),
      .o_occ_nxt  (w_occ_nxt)
   );

   // Stream FSM with end-of-stream tracking and sticky error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_last_seen <= 1'b0;
         r_err       <= 1'b0;
      end else if (in_flag_first) begin
         r_err       <= !w_flag_ok;
         r_last_seen <= w_last_acc;
         if (w_last_acc) begin
            r_state <= w_eos_state;
         end else if (w_wr_acc) begin
            r_state <= STREAM;
         end else begin
            r_state <= IDLE;
         end
      end else begin
         r_err <= r_err | !w_flag_ok | w_drop;
         if (w_last_acc) begin
            r_last_seen <= 1'b1;
         end
         case (r_state)
            IDLE, STREAM: begin
               if (w_last_acc) begin
                  r_state <= w_eos_state;
               end else if (w_wr_acc) begin
                  r_state <= STREAM;
               end
            end
            DRAIN: begin
               if (w_occ_nxt == '0) begin
                  r_state <= DONE;
               end
            end
            default: r_state <= DONE;
         endcase
      end
   end

   // Word presentation and padding decoded from registered state and occupancy.
   always_comb begin
      out_valid = 1'b0;
      out_pad   = 1'b0;
      out_eos   = 1'b0;
      out_data  = {w_byte0, w_byte1};
      case (r_state)
         STREAM: begin
            out_valid = w_occ >= OCC_WIDTH'(2);
         end
         DRAIN: begin
            out_valid = w_occ != '0;
            if (w_occ == OCC_WIDTH'(1)) begin
               out_pad  = 1'b1;
               out_data = {w_byte0, PAD_BYTE};
            end
         end
         DONE: begin
            out_valid = 1'b1;
            out_pad   = 1'b1;
            out_eos   = 1'b1;
            out_data  = {PAD_BYTE, PAD_BYTE};
         end
         default: begin
            out_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_bitstream_byte_reader.sv
// Directed bench for bitstream_byte_reader.
module tb_bitstream_byte_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_flag_first;
   logic [7:0]  in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5;
   logic [2:0]  in_flag;
   logic        in_flag_last;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_pad;
   logic        out_eos;
   logic [4:0]  occupancy;
   logic        err_sticky;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] q[$];
   logic [7:0] b_a, b_b;

   bitstream_byte_reader dut (
      .clk           (clk),
      .reset         (reset),
      .in_flag_first (in_flag_first),
      .in_bit_1      (in_bit_1),
      .in_bit_2      (in_bit_2),
      .in_bit_3      (in_bit_3),
      .in_bit_4      (in_bit_4),
      .in_bit_5      (in_bit_5),
      .in_flag       (in_flag),
      .in_flag_last  (in_flag_last),
      .in_ready      (in_ready),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pad       (out_pad),
      .out_eos       (out_eos),
      .occupancy     (occupancy),
      .err_sticky    (err_sticky)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic first, input logic [2:0] flag, input logic last,
                           input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] b4, input logic [7:0] b5);
      in_flag_first = first;
      in_flag       = flag;
      in_flag_last  = last;
      in_bit_1      = b1;
      in_bit_2      = b2;
      in_bit_3      = b3;
      in_bit_4      = b4;
      in_bit_5      = b5;
   endtask

   task automatic set_idle();
      set_beat(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
   endtask

   initial begin
      set_idle();
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_valid", 32'(out_valid), 32'h0);
      check_val("rst_ready", 32'(in_ready), 32'h1);
      check_val("rst_occ", 32'(occupancy), 32'h0);
      check_val("rst_err", 32'(err_sticky), 32'h0);

      reset = 1'b0;
      repeat (3) tick();
      check_val("idle_valid", 32'(out_valid), 32'h0);
      check_val("idle_ready", 32'(in_ready), 32'h1);
      check_val("idle_occ", 32'(occupancy), 32'h0);

      // Five bytes then two words, one byte left behind
      out_ready = 1'b1;
      set_beat(1'b0, 3'd5, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
      tick();
      set_idle();
      check_val("w1_valid", 32'(out_valid), 32'h1);
      check_val("w1_data", 32'(out_data), 32'h1122);
      check_val("w1_occ", 32'(occupancy), 32'h5);
      tick();
      check_val("w2_data", 32'(out_data), 32'h3344);
      tick();
      check_val("w3_valid", 32'(out_valid), 32'h0);
      check_val("w3_occ", 32'(occupancy), 32'h1);

      // Empty last beat: padded final word, then end-of-stream forever
      set_beat(1'b0, 3'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      tick();
      set_idle();
      check_val("drain_valid", 32'(out_valid), 32'h1);
      check_val("drain_data", 32'(out_data), 32'h5500);
      check_val("drain_pad", 32'(out_pad), 32'h1);
      tick();
      check_val("done_data", 32'(out_data), 32'h0000);
      check_val("done_eos", 32'(out_eos), 32'h1);
      check_val("done_valid", 32'(out_valid), 32'h1);
      repeat (3) tick();
      check_val("done_hold_eos", 32'(out_eos), 32'h1);
      check_val("done_hold_data", 32'(out_data), 32'h0000);
      check_val("done_hold_occ", 32'(occupancy), 32'h0);

      // New stream, fill to 15 without reading, then overflow
      out_ready = 1'b0;
      set_beat(1'b1, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      tick();
      check_val("restart_eos", 32'(out_eos), 32'h0);
      check_val("restart_occ", 32'(occupancy), 32'h0);
      set_beat(1'b0, 3'd5, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
      tick();
      set_beat(1'b0, 3'd5, 1'b0, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0a);
      tick();
      check_val("fill10_ready", 32'(in_ready), 32'h1);
      set_beat(1'b0, 3'd5, 1'b0, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f);
      tick();
      check_val("fill15_occ", 32'(occupancy), 32'hf);
      check_val("fill15_ready", 32'(in_ready), 32'h0);
      check_val("fill15_err", 32'(err_sticky), 32'h0);
      set_beat(1'b0, 3'd1, 1'b0, 8'hee, 8'h00, 8'h00, 8'h00, 8'h00);
      tick();
      set_idle();
      check_val("ovf_occ", 32'(occupancy), 32'hf);
      check_val("ovf_err", 32'(err_sticky), 32'h1);
      check_val("ovf_head", 32'(out_data), 32'h0102);

      // Restart with AA BB, then write CC DD EE while AABB fires
      set_beat(1'b1, 3'd2, 1'b0, 8'haa, 8'hbb, 8'h00, 8'h00, 8'h00);
      tick();
      check_val("ab_err", 32'(err_sticky), 32'h0);
      check_val("ab_occ", 32'(occupancy), 32'h2);
      check_val("ab_data", 32'(out_data), 32'haabb);
      out_ready = 1'b1;
      set_beat(1'b0, 3'd3, 1'b0, 8'hcc, 8'hdd, 8'hee, 8'h00, 8'h00);
      tick();
      set_idle();
      check_val("rw_occ", 32'(occupancy), 32'h3);
      check_val("rw_data", 32'(out_data), 32'hccdd);
      q = '{8'hcc, 8'hdd, 8'hee};

      // Steady two-in/two-out traffic that carries the pointers around the ring
      for (int it = 0; it < 8; it++) begin
         b_a = 8'(8'h40 + 2 * it);
         b_b = 8'(8'h41 + 2 * it);
         set_beat(1'b0, 3'd2, 1'b0, b_a, b_b, 8'h00, 8'h00, 8'h00);
         void'(q.pop_front());
         void'(q.pop_front());
         q.push_back(b_a);
         q.push_back(b_b);
         tick();
         check_val("wrap_data", 32'(out_data), 32'({q[0], q[1]}));
      end
      check_val("wrap_occ", 32'(occupancy), 32'(q.size()));

      // End of stream with three bytes held: one full word then a padded one
      set_beat(1'b0, 3'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      void'(q.pop_front());
      void'(q.pop_front());
      tick();
      set_idle();
      check_val("tail_data", 32'(out_data), 32'({q[0], 8'h00}));
      check_val("tail_pad", 32'(out_pad), 32'h1);
      tick();
      check_val("tail_eos", 32'(out_eos), 32'h1);

      // Write in DONE without restart is ignored and flagged
      out_ready = 1'b0;
      set_beat(1'b0, 3'd1, 1'b0, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00);
      tick();
      set_idle();
      check_val("done_wr_err", 32'(err_sticky), 32'h1);
      check_val("done_wr_occ", 32'(occupancy), 32'h0);

      // Restart from DONE with data while the zero word fires
      out_ready = 1'b1;
      set_beat(1'b1, 3'd2, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00);
      tick();
      set_idle();
      out_ready = 1'b0;
      check_val("first_err", 32'(err_sticky), 32'h0);
      check_val("first_occ", 32'(occupancy), 32'h2);
      check_val("first_data", 32'(out_data), 32'h0102);
      check_val("first_eos", 32'(out_eos), 32'h0);

      // Illegal lane count
      set_beat(1'b0, 3'd6, 1'b0, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99);
      tick();
      set_idle();
      check_val("ill_err", 32'(err_sticky), 32'h1);
      check_val("ill_occ", 32'(occupancy), 32'h2);

      // Asynchronous reset mid-stream
      #2;
      reset = 1'b1;
      #1;
      check_val("arst_occ", 32'(occupancy), 32'h0);
      check_val("arst_valid", 32'(out_valid), 32'h0);
      check_val("arst_err", 32'(err_sticky), 32'h0);
      check_val("arst_ready", 32'(in_ready), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
